// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver (5-8 data bits, optional parity, 1/2 stop) feeding a
// first-word-fall-through FIFO with per-entry error flags and RTS. Break detection: UART_RX_BREAK_DET_EN.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int RTS_MARGIN   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic [1:0]             data_bit_num,
  input  logic                   stop_bit_num,
  input  logic                   parity_en,
  input  logic                   parity_type,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic                   rd_parity_err,
  output logic                   rd_frame_err,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   rts_n,
  output logic                   rx_done,
  output logic                   overrun,
  output logic                   break_det
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_TICK  = CW'(1);
  localparam logic [AW:0]   RTS_LEVEL = (AW + 1)'(DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic parity_error(input logic [7:0] data, input logic par_bit, input logic odd);
    parity_error = ((^data) ^ par_bit) != odd;
  endfunction

  state_t        state_r, state_next;
  logic          sync1_r, sync2_r, rx_prev_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic          stop_idx_r;
  logic [1:0]    cfg_bits_r;
  logic          cfg_stop2_r, cfg_par_en_r, cfg_par_odd_r;
  logic [7:0]    data_r;
  logic          par_err_r, frame_err_r;
  logic          tick_s, push_s;
  logic [9:0]    entry_s;
  logic          rx_done_r, rts_n_r, overrun_r;
`ifdef UART_RX_BREAK_DET_EN
  logic          brk_s, break_det_r, par_bit_r;
`endif

  logic [9:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r, count_s, count_next_s;
  logic          pop_s, wr_ok_s, drop_s;
  logic [9:0]    head_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r   <= rx;
      sync2_r   <= sync1_r;
      rx_prev_r <= sync2_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_next;
  end

  // Next-state logic; the final stop sample pushes the completed frame in the same edge
  always_comb begin
    state_next = state_r;
    tick_s     = 1'b0;
    push_s     = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_s      = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (rx_prev_r && !sync2_r) state_next = S_START;
        else                       state_next = S_IDLE;
      end
      S_START: begin
        tick_s = (cnt_r == HALF_TICK);
        if (tick_s) state_next = sync2_r ? S_IDLE : S_DATA;
        else        state_next = S_START;
      end
      S_DATA: begin
        tick_s = (cnt_r == FULL_TICK);
        if (tick_s && (bit_idx_r == ({1'b0, cfg_bits_r} + 3'd4)))
          state_next = cfg_par_en_r ? S_PARITY : S_STOP;
        else
          state_next = S_DATA;
      end
      S_PARITY: begin
        tick_s = (cnt_r == FULL_TICK);
        if (tick_s) state_next = S_STOP;
        else        state_next = S_PARITY;
      end
      S_STOP: begin
        tick_s = (cnt_r == FULL_TICK);
        if (!tick_s) begin
          state_next = S_STOP;
`ifdef UART_RX_BREAK_DET_EN
        end else if (!stop_idx_r && !sync2_r && (data_r == 8'h00) && !par_bit_r) begin
          brk_s      = 1'b1;
          state_next = S_BREAK;
`endif
        end else if (stop_idx_r == cfg_stop2_r) begin
          push_s     = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_STOP;
        end
      end
      S_BREAK: begin
        if (sync2_r) state_next = S_IDLE;
        else         state_next = S_BREAK;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign entry_s = {frame_err_r | ~sync2_r, par_err_r, data_r};

  // Bit timing, configuration latch and frame assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r         <= {CW{1'b0}};
      bit_idx_r     <= 3'd0;
      stop_idx_r    <= 1'b0;
      cfg_bits_r    <= 2'd0;
      cfg_stop2_r   <= 1'b0;
      cfg_par_en_r  <= 1'b0;
      cfg_par_odd_r <= 1'b0;
      data_r        <= 8'h00;
      par_err_r     <= 1'b0;
      frame_err_r   <= 1'b0;
      rx_done_r     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit_r     <= 1'b0;
      break_det_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_START: begin
          if (tick_s) begin
            cnt_r         <= {CW{1'b0}};
            bit_idx_r     <= 3'd0;
            stop_idx_r    <= 1'b0;
            cfg_bits_r    <= data_bit_num;
            cfg_stop2_r   <= stop_bit_num;
            cfg_par_en_r  <= parity_en;
            cfg_par_odd_r <= parity_type;
            data_r        <= 8'h00;
            par_err_r     <= 1'b0;
            frame_err_r   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_r     <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + ONE_TICK;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            cnt_r             <= {CW{1'b0}};
            data_r[bit_idx_r] <= sync2_r;
            bit_idx_r         <= bit_idx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + ONE_TICK;
          end
        end
        S_PARITY: begin
          if (tick_s) begin
            cnt_r     <= {CW{1'b0}};
            par_err_r <= parity_error(data_r, sync2_r, cfg_par_odd_r);
`ifdef UART_RX_BREAK_DET_EN
            par_bit_r <= sync2_r;
`endif
          end else begin
            cnt_r <= cnt_r + ONE_TICK;
          end
        end
        S_STOP: begin
          if (tick_s) begin
            cnt_r      <= {CW{1'b0}};
            stop_idx_r <= 1'b1;
            if (!sync2_r) frame_err_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + ONE_TICK;
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
      rx_done_r <= push_s;
`ifdef UART_RX_BREAK_DET_EN
      break_det_r <= brk_s;
`endif
    end
  end

  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign fifo_empty   = (wr_ptr_r == rd_ptr_r);
  assign fifo_full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s        = rd_en && !fifo_empty;
  assign wr_ok_s      = push_s && (!fifo_full || pop_s);
  assign drop_s       = push_s && fifo_full && !pop_s;
  assign count_next_s = count_s + {{AW{1'b0}}, wr_ok_s} - {{AW{1'b0}}, pop_s};
  assign head_s       = mem[rd_ptr_r[AW-1:0]];

  // FIFO storage; contents are only observed through the empty-gated head
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem[wr_ptr_r[AW-1:0]] <= entry_s;
  end

  // Pointers, overrun flag and registered RTS threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {(AW + 1){1'b0}};
      rd_ptr_r  <= {(AW + 1){1'b0}};
      overrun_r <= 1'b0;
      rts_n_r   <= 1'b1;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)   rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)       overrun_r <= 1'b0;
      else if (drop_s) overrun_r <= 1'b1;
      rts_n_r <= (count_next_s >= RTS_LEVEL);
    end
  end

  assign rd_data       = fifo_empty ? 8'h00 : head_s[7:0];
  assign rd_parity_err = !fifo_empty && head_s[8];
  assign rd_frame_err  = !fifo_empty && head_s[9];
  assign fifo_count    = count_s;
  assign rts_n         = rts_n_r;
  assign rx_done       = rx_done_r;
  assign overrun       = overrun_r;
`ifdef UART_RX_BREAK_DET_EN
  assign break_det     = break_det_r;
`else
  assign break_det     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed serial frames, a queue-based FIFO model compared every cycle,
// and literal expectations taken from hand-computed frame contents.
module tb_uart_rx_fifo;
  localparam int CPB    = 16;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] data_bit_num = 2'd3;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_parity_err, rd_frame_err, fifo_empty, fifo_full;
  logic [3:0] fifo_count;
  logic       rts_n, rx_done, overrun, break_det;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type), .rd_en(rd_en), .rd_data(rd_data),
    .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .rts_n(rts_n), .rx_done(rx_done),
    .overrun(overrun), .break_det(break_det)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] mq[$];
  logic [9:0] pend[$];
  logic       m_ovr = 1'b0;
  logic       rd_en_q = 1'b0;
  int         since = 0;
  int         done_cnt = 0;
  int         brk_cnt = 0;
  int         brk_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
    cycles(1);
  endtask

  // Model: frames expected from the line move into the FIFO model when the frame completes
  always @(negedge clk) begin
    logic [9:0] e;
    logic       popped, was_full;
    if (reset) begin
      mq.delete();
      m_ovr = 1'b0;
      since = 0;
      rd_en_q = 1'b0;
      check("reset_empty", fifo_empty, 1);
      check("reset_count", fifo_count, 0);
      check("reset_rts", rts_n, 1);
      check("reset_done", rx_done, 0);
      check("reset_ovr", overrun, 0);
      check("reset_data", rd_data, 0);
    end else begin
      since++;
      was_full = (mq.size() == DEPTH);
      popped = rd_en_q && (mq.size() > 0);
      if (popped) begin
        void'(mq.pop_front());
        m_ovr = 1'b0;
      end
      if (rx_done) begin
        done_cnt++;
        if (pend.size() == 0) begin
          check("unexpected_rx_done", 1, 0);
        end else begin
          e = pend.pop_front();
          if (!was_full || popped) mq.push_back(e);
          else m_ovr = 1'b1;
        end
      end
      if (break_det) brk_cnt++;
      e = (mq.size() > 0) ? mq[0] : 10'h000;
      check("cyc_data", rd_data, e[7:0]);
      check("cyc_perr", rd_parity_err, e[8]);
      check("cyc_ferr", rd_frame_err, e[9]);
      check("cyc_empty", fifo_empty, mq.size() == 0);
      check("cyc_full", fifo_full, mq.size() == DEPTH);
      check("cyc_count", fifo_count, mq.size());
      check("cyc_rts", rts_n, (since <= 1) ? 1 : (mq.size() >= DEPTH - MARGIN));
      check("cyc_ovr", overrun, m_ovr);
      rd_en_q = rd_en;
    end
  end

  task automatic send_frame(input logic [7:0] d, input int nb, input int ns, input logic pen,
                            input logic pt, input logic pbit, input logic s0, input logic s1);
    logic [7:0] m;
    logic       perr, ferr, brk;
    m    = d & (8'hFF >> (8 - nb));
    perr = pen && ((($countones(m) + int'(pbit)) % 2) != int'(pt));
    ferr = !s0 || ((ns == 2) && !s1);
    brk  = (m == 8'h00) && (!pen || !pbit) && !s0;
`ifdef UART_RX_BREAK_DET_EN
    if (brk) brk_exp++;
    else pend.push_back({ferr, perr, m});
`else
    pend.push_back({ferr, perr, m});
`endif
    data_bit_num = 2'(nb - 5);
    stop_bit_num = (ns == 2);
    parity_en    = pen;
    parity_type  = pt;
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < nb; i++) begin
      rx = d[i];
      cycles(CPB);
    end
    if (pen) begin
      rx = pbit;
      cycles(CPB);
    end
    rx = s0;
    cycles(CPB);
    if (ns == 2) begin
      rx = s1;
      cycles(CPB);
    end
    rx = 1'b1;
    cycles(3 * CPB);
    check("frame_completed", pend.size(), 0);
    check("break_count", brk_cnt, brk_exp);
  endtask

  initial begin
    int done0;
    cycles(3);
    check("rst_rts_lit", rts_n, 1);
    reset = 1'b0;
    cycles(3);
    check("rts_after_rst_lit", rts_n, 0);

    send_frame(8'hA5, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("a5_data", rd_data, 8'hA5);
    check("a5_perr", rd_parity_err, 0);
    check("a5_ferr", rd_frame_err, 0);
    check("a5_count", fifo_count, 1);
    do_read();
    check("a5_empty_after_read", fifo_empty, 1);

    send_frame(8'h35, 7, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("7e1_data", rd_data, 8'h35);
    check("7e1_perr", rd_parity_err, 1);
    check("7e1_ferr", rd_frame_err, 0);
    do_read();

    send_frame(8'h2A, 6, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("6o1_data", rd_data, 8'h2A);
    check("6o1_perr", rd_parity_err, 0);
    do_read();

    send_frame(8'h15, 5, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h0A, 5, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("5b_data", rd_data, 8'h15);
    check("5b_ferr", rd_frame_err, 1);
    do_read();
    check("5b_next_data", rd_data, 8'h0A);
    check("5b_next_ferr", rd_frame_err, 0);
    do_read();
    check("rd_empty_no_effect_pre", fifo_count, 0);
    do_read();
    check("rd_empty_no_effect", fifo_count, 0);

    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 8, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (i == 4) check("rts_below_thresh", rts_n, 0);
      if (i == 5) check("rts_at_thresh", rts_n, 1);
    end
    check("ovf_count", fifo_count, 8);
    check("ovf_full", fifo_full, 1);
    check("ovf_flag", overrun, 1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", rd_data, i);
      do_read();
      if (i == 0) check("ovf_cleared", overrun, 0);
    end
    check("ovf_drained", fifo_empty, 1);

    done0 = done_cnt;
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(3 * CPB);
    check("false_start", done_cnt, done0);

    send_frame(8'h55, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rx = 1'b0;
    cycles(CPB);
    rx = 1'b1;
    cycles(CPB);
    rx = 1'b0;
    cycles(CPB);
    rx = 1'b1;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(2);
    check("mid_reset_empty", fifo_empty, 1);
    send_frame(8'h3C, 8, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("after_reset_data", rd_data, 8'h3C);
    do_read();

`ifdef UART_RX_BREAK_DET_EN
    brk_exp++;
`else
    pend.push_back({1'b1, 1'b0, 8'h00});
`endif
    data_bit_num = 2'd3;
    stop_bit_num = 1'b0;
    parity_en = 1'b0;
    rx = 1'b0;
    cycles(12 * CPB);
    rx = 1'b1;
    cycles(3 * CPB);
    check("break_pending", pend.size(), 0);
`ifdef UART_RX_BREAK_DET_EN
    check("break_pulse", brk_cnt, 1);
    check("break_count", fifo_count, 0);
`else
    check("break_tied", brk_cnt, 0);
    check("break_data", rd_data, 8'h00);
    check("break_ferr", rd_frame_err, 1);
    check("break_count", fifo_count, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
